sub_32bit_pipe: RTL and testbench
=================================

SUB_32BIT_PIPE -- requirements
Module: sub_32bit_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even, and the bench SHALL only use 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  downstream accepts result this cycle.
REQ-011 diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
REQ-012 bout  output  1  borrow-out; 1 iff unsigned a < b + bin.
REQ-013 flag_z / flag_n / flag_v  output  1 each  diff==0 / diff[MSB] / signed overflow.

Function
REQ-014 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-015 Two-stage pipeline. Stage 1 registers low half a[H-1:0]-b[H-1:0]-bin, its borrow, upper halves of a and b, and the sign bits.
REQ-016 Stage 2 registers upper half a_hi-b_hi-borrow_lo, concatenates it with the low half, and produces bout and flags.
REQ-017 Latency exactly 2 cycles from input transfer to out_valid when there is no back-pressure; throughput one beat per cycle.
REQ-018 Stage 2 advances when !out_valid || out_ready.
REQ-019 Stage 1 advances when !s1_valid || stage 2 advances.
REQ-020 in_ready = !s1_valid || stage-2 advance; purely combinational from state and out_ready.
REQ-021 While out_valid && !out_ready: diff, bout and flags SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-022 flag_v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the a and b of the same beat.
REQ-023 Wrap-around is modular: 0 - 1 yields all-ones with bout=1; no saturation.
REQ-024 bin=1 with a==b yields all-ones and bout=1; a==b with bin=0 yields 0, bout=0, flag_z=1.
REQ-025 Simultaneous output drain and input accept in the same cycle SHALL sustain full throughput with order preserved.
REQ-026 Data registers need not be reset; valid bits SHALL be.

Reset
REQ-027 rst=1 asynchronously clears s1_valid and out_valid. in_ready SHALL read 1 at the first edge after deassertion.
REQ-028 Reset mid-operation discards all in-flight beats; no out_valid may appear for pre-reset beats.
REQ-029 diff, bout and flags SHALL read 0 while out_valid=0 after reset.

Structure
REQ-030 Shared package arch_pkg SHALL hold WIDTH=32 and HALF=WIDTH/2, plus a flags struct {z,n,v}.
REQ-031 A combinational sub-module sub_half (HALF-bit a-b-bin giving diff and bout) SHALL be instantiated once per stage.
REQ-032 No latches; all flops use async-reset style, and only the valid flops carry reset.

Verification
REQ-033 a=0x00000005, b=0x00000003, bin=0 -> diff=0x00000002, bout=0, z=0, n=0, v=0, out_valid 2 cycles after accept.
REQ-034 a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, n=1, v=0. Also a=0x00010000, b=0x00000001 -> 0x0000FFFF (half-boundary borrow).
REQ-035 a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, v=1, bout=0. Also a=0x12345678, b=0x12345678, bin=1 -> 0xFFFFFFFF, bout=1.
REQ-036 Stream 8 back-to-back beats with out_ready=1 -> 8 results on consecutive cycles, in order, matching reference model.
REQ-037 Hold out_ready=0 for 5 cycles after 3 beats -> in_ready drops after 2 beats, outputs stable; on release, all 3 delivered once, in order.
REQ-038 Assert rst with 2 beats in flight -> out_valid=0 immediately, in_ready=1 after release, no stale beat emitted.

Source files
------------

// File: rtl/arch_pkg.sv
// Shared widths and result-flag bundle for the split-borrow subtractor pipeline.
package arch_pkg;
  localparam int WIDTH = 32;
  localparam int HALF  = WIDTH / 2;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;
endpackage

// File: rtl/sub_half.sv
// Combinational half-width subtract: diff = a - b - bin, bout set when a < b + bin.
module sub_half
  import arch_pkg::*;
#(
  parameter int W = HALF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] res;

  // The extra top bit of the widened difference is the borrow.
  assign res  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff = res[W-1:0];
  assign bout = res[W];

endmodule

// File: rtl/sub_32bit_pipe.sv
// Two-stage valid/ready subtractor: stage 1 does the low half, stage 2 the high half and flags.
module sub_32bit_pipe #(
  parameter int WIDTH = arch_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int H = WIDTH / 2;

  logic             s1_valid;
  logic [H-1:0]     s1_dlo;
  logic             s1_blo;
  logic [H-1:0]     s1_ahi;
  logic [H-1:0]     s1_bhi;
  logic             s1_amsb;
  logic             s1_bmsb;

  logic [WIDTH-1:0] s2_diff;
  logic             s2_bout;
  arch_pkg::flags_t s2_flags;

  logic             adv2;
  logic             adv1;
  logic             in_xfer;

  logic [H-1:0]     lo_diff;
  logic             lo_bout;
  logic [H-1:0]     hi_diff;
  logic             hi_bout;
  logic [WIDTH-1:0] diff_nxt;
  arch_pkg::flags_t flags_nxt;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign in_xfer  = in_valid && in_ready;

  sub_half #(.W(H)) u_sub_lo (
    .a    (a[H-1:0]),
    .b    (b[H-1:0]),
    .bin  (bin),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  sub_half #(.W(H)) u_sub_hi (
    .a    (s1_ahi),
    .b    (s1_bhi),
    .bin  (s1_blo),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  assign diff_nxt    = {hi_diff, s1_dlo};
  assign flags_nxt.z = (diff_nxt == '0);
  assign flags_nxt.n = diff_nxt[WIDTH-1];
  // Overflow uses the operand signs carried alongside the beat, never the live inputs.
  assign flags_nxt.v = (s1_amsb != s1_bmsb) && (diff_nxt[WIDTH-1] != s1_amsb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid  <= in_valid;
      if (adv2) out_valid <= s1_valid;
    end
  end

  // Payload registers carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_dlo  <= lo_diff;
      s1_blo  <= lo_bout;
      s1_ahi  <= a[WIDTH-1:H];
      s1_bhi  <= b[WIDTH-1:H];
      s1_amsb <= a[WIDTH-1];
      s1_bmsb <= b[WIDTH-1];
    end
    if (adv2 && s1_valid) begin
      s2_diff  <= diff_nxt;
      s2_bout  <= hi_bout;
      s2_flags <= flags_nxt;
    end
  end

  // Gate the unreset payload so an idle output reads as all zeros.
  assign diff   = out_valid ? s2_diff : '0;
  assign bout   = out_valid && s2_bout;
  assign flag_z = out_valid && s2_flags.z;
  assign flag_n = out_valid && s2_flags.n;
  assign flag_v = out_valid && s2_flags.v;

endmodule

// File: tb/tb_sub_32bit_pipe.sv
// Scoreboard bench for sub_32bit_pipe: expected results queued at input accept, checked at output.
module tb_sub_32bit_pipe;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        n;
    logic        v;
    int          due;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        bout;
  logic        flag_z;
  logic        flag_n;
  logic        flag_v;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   rnd_done = 0;
  exp_t sb[$];

  sub_32bit_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a_i, input logic [31:0] b_i, input logic bin_i);
    exp_t e;
    e.d   = a_i - b_i - {31'd0, bin_i};
    e.bo  = ({1'b0, a_i} < ({1'b0, b_i} + {32'd0, bin_i}));
    e.z   = (e.d == 32'd0);
    e.n   = e.d[31];
    e.v   = (a_i[31] != b_i[31]) && (e.d[31] != a_i[31]);
    e.due = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [31:0] a_i, input logic [31:0] b_i, input logic bin_i, input bit lat);
    exp_t e;
    int   n;
    a = a_i; b = b_i; bin = bin_i; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    e = model(a_i, b_i, bin_i);
    e.due = cyc + 2;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_acc++;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {63'd0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("diff", {32'd0, diff}, {32'd0, e.d});
        check("bout_zvn", {60'd0, bout, flag_z, flag_n, flag_v}, {60'd0, e.bo, e.z, e.n, e.v});
        if (e.lat) check("latency", 64'(cyc), 64'(e.due));
        n_out++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int w;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs_zero", {28'd0, diff, bout, flag_z, flag_n, flag_v}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Directed corners, back to back with latency checked.
    send(32'h00000005, 32'h00000003, 1'b0, 1);
    send(32'h00000000, 32'h00000001, 1'b0, 1);
    send(32'h00010000, 32'h00000001, 1'b0, 1);
    send(32'h80000000, 32'h00000001, 1'b0, 1);
    send(32'h12345678, 32'h12345678, 1'b1, 1);
    send(32'h12345678, 32'h12345678, 1'b0, 1);
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1);
    send(32'h80000000, 32'h00000000, 1'b1, 1);
    wait_drain();

    // Eight random beats streamed with no back-pressure.
    for (int i = 0; i < 8; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1);
    wait_drain();

    // Back-pressure: three beats against a stalled output.
    out_ready = 1'b0;
    n_acc = 0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
      end
      begin
        w = 0;
        while (n_acc < 2 && w < 60) begin
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 5; k++) begin
          if (k != 0) @(negedge clk);
          check("stall_out_valid", {63'd0, out_valid}, 64'd1);
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          check("stall_diff", {32'd0, diff}, {32'd0, sb[0].d});
          check("stall_bout_zvn", {60'd0, bout, flag_z, flag_n, flag_v},
                {60'd0, sb[0].bo, sb[0].z, sb[0].n, sb[0].v});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stall_out_count", 64'(n_out - base), 64'd3);

    // Random stream with random back-pressure and input gaps.
    base = n_out;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = $urandom;
          rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
          send(ra, rb, 1'($urandom_range(0, 1)), 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("random_out_count", 64'(n_out - base), 64'd40);

    // Reset with two beats in flight.
    out_ready = 1'b1;
    send(32'hDEADBEEF, 32'h00000001, 1'b0, 0);
    send(32'hCAFEF00D, 32'h00000002, 1'b0, 0);
    check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_outputs_zero", {28'd0, diff, bout, flag_z, flag_n, flag_v}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_out", {63'd0, out_valid}, 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
